// File: rtl/pricer_host_ctrl_pkg.sv
// Shared definitions for the pricer host controller.
//   - pricer mode encodings driven on dut_state
//   - default path geometry (DAY words per path, N_PATH paths per run)
//   - FSM state encoding and a helper mapping a state to its pricer mode
package pricer_host_ctrl_pkg;

   localparam int DAY_DEFAULT    = 8;
   localparam int N_PATH_DEFAULT = 256;

   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_PARAM = 2'd1;
   localparam logic [1:0] MODE_GEN   = 2'd2;
   localparam logic [1:0] MODE_PRICE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_PARAM = 3'd2,
      ST_GEN   = 3'd3,
      ST_PRICE = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   // ARM shares the parameter mode with PARAM; DONE and ERR look idle to the pricer.
   function automatic logic [1:0] mode_of(state_e s);
      case (s)
         ST_ARM, ST_PARAM: return MODE_PARAM;
         ST_GEN:           return MODE_GEN;
         ST_PRICE:         return MODE_PRICE;
         default:          return MODE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/pricer_host_ctrl_path_buffer.sv
// path_buffer: DEPTH x WIDTH simple dual-port memory holding the generated paths.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address, sampled on the rising edge
//   rdata_o  out  registered read data (one cycle after raddr_i)
// Contents and the read register are deliberately not reset so the array maps
// onto block RAM.
module path_buffer #(
   parameter int DEPTH = 2048,
   parameter int WIDTH = 12,
   parameter int AW    = 11
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pricer_host_ctrl.sv
// pricer_host_ctrl: sequences one pricing job on an external pricer.
// Loads four parameters, captures DAY*N_PATH generated path words into a
// buffer, replays them (with per-path rewind on request) until the pricer
// returns a price. A watchdog aborts to ERR if the pricer goes quiet.
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_start                   job request (accepted only in IDLE)
//   w_in, q_in, s_in, k_in      job parameters, sampled on acceptance
//   dut_state / dut_in          mode and data word to the pricer
//   dut_valid/dut_out/dut_resend  pricer response
//   price, busy, done, error    job result and status
module pricer_host_ctrl
   import pricer_host_ctrl_pkg::*;
#(
   parameter int DAY     = DAY_DEFAULT,
   parameter int N_PATH  = N_PATH_DEFAULT,
   parameter int TIMEOUT = 8191
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_start,
   input  logic [11:0] w_in,
   input  logic [11:0] q_in,
   input  logic [11:0] s_in,
   input  logic [11:0] k_in,
   output logic [1:0]  dut_state,
   output logic [11:0] dut_in,
   input  logic        dut_valid,
   input  logic [11:0] dut_out,
   input  logic        dut_resend,
   output logic [11:0] price,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int DEPTH = DAY * N_PATH;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WW    = $clog2(TIMEOUT + 1);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] DAY_A     = AW'(DAY);
   localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

   state_e        state_q, state_d;
   logic [11:0]   w_q, w_d, q_q, q_d, s_q, s_d, k_q, k_d;
   logic [1:0]    param_cnt_q, param_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [11:0]   price_q, price_d;
   logic          error_q, error_d;
   logic          buf_we;
   logic [11:0]   buf_rdata;

   // rd_ptr_q is the address of the word currently on dut_in during PRICE.
   // The buffer is addressed with rd_ptr_d so the registered read lands on
   // dut_in exactly when rd_ptr_q takes that value; outside PRICE rd_ptr_d
   // is 0, which pre-loads buffer[0] for the first PRICE cycle.
   path_buffer #(
      .DEPTH(DEPTH),
      .WIDTH(12),
      .AW   (AW)
   ) u_buf (
      .clk    (clk),
      .we_i   (buf_we),
      .waddr_i(wr_ptr_q),
      .wdata_i(dut_out),
      .raddr_i(rd_ptr_d),
      .rdata_o(buf_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         q_q         <= '0;
         s_q         <= '0;
         k_q         <= '0;
         param_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wd_q        <= '0;
         price_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         q_q         <= q_d;
         s_q         <= s_d;
         k_q         <= k_d;
         param_cnt_q <= param_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wd_q        <= wd_d;
         price_q     <= price_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      q_d         = q_q;
      s_d         = s_q;
      k_d         = k_q;
      param_cnt_d = param_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = '0;
      price_d     = price_q;
      error_d     = error_q;
      buf_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_start) begin
               w_d     = w_in;
               q_d     = q_in;
               s_d     = s_in;
               k_d     = k_in;
               error_d = 1'b0;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            wr_ptr_d    = '0;
            param_cnt_d = '0;
            state_d     = ST_PARAM;
         end
         ST_PARAM: begin
            param_cnt_d = param_cnt_q + 2'd1;
            if (param_cnt_q == 2'd3) begin
               state_d = ST_GEN;
            end
         end
         ST_GEN: begin
            if (dut_valid) begin
               buf_we   = 1'b1;
               wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
               if (wr_ptr_q == LAST_ADDR) begin
                  state_d = ST_PRICE;
               end
            end else if (wd_q == TIMEOUT_W) begin
               error_d = 1'b1;
               state_d = ST_ERR;
            end
         end
         ST_PRICE: begin
            // A returned price takes priority over a simultaneous resend.
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
            if (dut_valid) begin
               price_d = dut_out;
               state_d = ST_DONE;
            end else if (wd_q == TIMEOUT_W) begin
               error_d = 1'b1;
               state_d = ST_ERR;
            end else if (dut_resend) begin
               rd_ptr_d = (rd_ptr_q / DAY_A) * DAY_A;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Watchdog: restarts on any state change or pricer activity and only
      // accumulates while waiting on the pricer.
      if ((state_d != state_q) || dut_valid) begin
         wd_d = '0;
      end else if ((state_q == ST_GEN) || (state_q == ST_PRICE)) begin
         wd_d = wd_q + 1'b1;
      end else begin
         wd_d = '0;
      end
   end

   always_comb begin
      dut_in = '0;
      case (state_q)
         ST_PARAM: begin
            case (param_cnt_q)
               2'd0:    dut_in = w_q;
               2'd1:    dut_in = q_q;
               2'd2:    dut_in = s_q;
               default: dut_in = k_q;
            endcase
         end
         ST_PRICE: dut_in = buf_rdata;
         default:  dut_in = '0;
      endcase
   end

   assign dut_state = mode_of(state_q);
   assign busy      = (state_q == ST_ARM) || (state_q == ST_PARAM) ||
                      (state_q == ST_GEN) || (state_q == ST_PRICE);
   assign done      = (state_q == ST_DONE);
   assign error     = error_q;
   assign price     = price_q;

endmodule

// File: tb/tb_pricer_host_ctrl.sv
module tb_pricer_host_ctrl;

   localparam int DAY     = 8;
   localparam int N_PATH  = 256;
   localparam int DEPTH   = DAY * N_PATH;
   localparam int TIMEOUT = 8191;

   logic        clk;
   logic        rst_n;
   logic        cmd_start;
   logic [11:0] w_in, q_in, s_in, k_in;
   logic [1:0]  dut_state;
   logic [11:0] dut_in;
   logic        dut_valid;
   logic [11:0] dut_out;
   logic        dut_resend;
   logic [11:0] price;
   logic        busy, done, error;

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   logic [11:0] exp_buf [DEPTH];

   pricer_host_ctrl #(
      .DAY    (DAY),
      .N_PATH (N_PATH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_start (cmd_start),
      .w_in      (w_in),
      .q_in      (q_in),
      .s_in      (s_in),
      .k_in      (k_in),
      .dut_state (dut_state),
      .dut_in    (dut_in),
      .dut_valid (dut_valid),
      .dut_out   (dut_out),
      .dut_resend(dut_resend),
      .price     (price),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1, "global timeout");
   end

   task automatic start_job(input logic [11:0] w, input logic [11:0] q,
                            input logic [11:0] s, input logic [11:0] k);
      cmd_start = 1'b1;
      w_in = w; q_in = q; s_in = s; k_in = k;
      @(negedge clk);
      cmd_start = 1'b0;
      w_in = 12'($urandom); q_in = 12'($urandom);
      s_in = 12'($urandom); k_in = 12'($urandom);
      $display("job started w=%03h q=%03h s=%03h k=%03h", w, q, s, k);
   endtask

   // Expect one zero word in ARM then the four parameters; optionally poke a
   // competing cmd_start mid-sequence, which must be ignored.
   task automatic test_param(input logic [11:0] w, input logic [11:0] q,
                             input logic [11:0] s, input logic [11:0] k,
                             input bit poke);
      logic [11:0] seq [5];
      seq[0] = 12'h000; seq[1] = w; seq[2] = q; seq[3] = s; seq[4] = k;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dut_state !== 2'd1 || dut_in !== seq[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL param[%0d]: state=%0d dut_in=%03h busy=%b, required state=1 dut_in=%03h busy=1",
                     i, dut_state, dut_in, busy, seq[i]);
         end
         cmd_start = poke && (i == 2);
         @(negedge clk);
      end
      cmd_start = 1'b0;
      checks++;
      if (dut_state !== 2'd2) begin
         errors++;
         $display("FAIL param_exit: state=%0d required 2", dut_state);
      end
      $display("param phase checked");
   endtask

   task automatic fill_gen(input bit addr_data, input int pct);
      int addr = 0;
      int cyc  = 0;
      logic [11:0] data;
      while (addr < DEPTH && cyc < 20 * DEPTH) begin
         checks++;
         if (dut_state !== 2'd2) begin
            errors++;
            $display("FAIL gen_state: at word %0d state=%0d required 2", addr, dut_state);
            break;
         end
         if ($urandom_range(99) < pct) begin
            data = addr_data ? 12'(addr) : 12'($urandom);
            exp_buf[addr] = data;
            dut_valid = 1'b1;
            dut_out   = data;
            addr++;
         end else begin
            dut_valid = 1'b0;
            dut_out   = 12'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      dut_valid = 1'b0;
      dut_out   = '0;
      checks++;
      if (dut_state !== 2'd3) begin
         errors++;
         $display("FAIL gen_exit: state=%0d required 3", dut_state);
      end
      $display("gen phase: %0d words in %0d cycles", addr, cyc);
   endtask

   // Reference: the word shown is exp_buf[pos]; a resend returns pos to the
   // first word of its path, otherwise pos steps forward around the buffer.
   task automatic stream_price(input int ncyc, input int resend_pct, input int resend_at,
                               input logic [11:0] p, input bit both);
      int pos = 0;
      bit fired = 0;
      bit r;
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (dut_state !== 2'd3 || dut_in !== exp_buf[pos]) begin
            errors++;
            $display("FAIL price_stream[%0d]: state=%0d dut_in=%03h, required state=3 dut_in=%03h (pos %0d)",
                     c, dut_state, dut_in, exp_buf[pos], pos);
            break;
         end
         r = (!fired && pos == resend_at) || ($urandom_range(99) < resend_pct);
         if (pos == resend_at) fired = 1;
         dut_resend = r;
         @(negedge clk);
         pos = r ? (pos / DAY) * DAY : (pos + 1) % DEPTH;
      end
      dut_resend = both;
      dut_valid  = 1'b1;
      dut_out    = p;
      @(negedge clk);
      dut_valid  = 1'b0;
      dut_resend = 1'b0;
      dut_out    = '0;
      checks++;
      if (done !== 1'b1 || dut_state !== 2'd0 || busy !== 1'b0 || price !== p) begin
         errors++;
         $display("FAIL price_done: done=%b state=%0d busy=%b price=%03h, required done=1 state=0 busy=0 price=%03h",
                  done, dut_state, busy, price, p);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || dut_state !== 2'd0 || price !== p) begin
         errors++;
         $display("FAIL price_after: done=%b state=%0d price=%03h, required done=0 state=0 price=%03h",
                  done, dut_state, price, p);
      end
      $display("price phase: streamed %0d cycles, price=%03h", ncyc, p);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_start = 0; w_in = 0; q_in = 0; s_in = 0; k_in = 0;
      dut_valid = 0; dut_out = 0; dut_resend = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_state !== 2'd0 || dut_in !== 12'h000 || price !== 12'h000 ||
          busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset: state=%0d dut_in=%03h price=%03h busy=%b done=%b error=%b, required all 0",
                  dut_state, dut_in, price, busy, done, error);
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset checked");
   endtask

   task automatic test_directed_job();
      start_job(12'h010, 12'h020, 12'h400, 12'h3C0);
      test_param(12'h010, 12'h020, 12'h400, 12'h3C0, 1'b0);
      fill_gen(1'b1, 100);
      stream_price(40, 0, 13, 12'h155, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [11:0] w, q, s, k;
      for (int j = 0; j < 2; j++) begin
         w = 12'($urandom); q = 12'($urandom); s = 12'($urandom); k = 12'($urandom);
         start_job(w, q, s, k);
         test_param(w, q, s, k, 1'b1);
         fill_gen(1'b0, 60);
         stream_price(200, 10, -1, 12'($urandom), 1'b1);
      end
   endtask

   task automatic test_wrap();
      logic [11:0] w;
      w = 12'($urandom);
      start_job(w, ~w, w ^ 12'h5A5, 12'h0F0);
      test_param(w, ~w, w ^ 12'h5A5, 12'h0F0, 1'b0);
      fill_gen(1'b0, 100);
      stream_price(DEPTH + 40, 0, -1, 12'($urandom), 1'b0);
   endtask

   task automatic test_timeout();
      int n = 0;
      int dc;
      dc = done_count;
      start_job(12'h111, 12'h222, 12'h333, 12'h444);
      repeat (5) @(negedge clk);
      checks++;
      if (dut_state !== 2'd2) begin
         errors++;
         $display("FAIL timeout_enter_gen: state=%0d required 2", dut_state);
      end
      while (dut_state === 2'd2 && n < TIMEOUT + 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < TIMEOUT || n > TIMEOUT + 2) begin
         errors++;
         $display("FAIL timeout_len: gen lasted %0d idle cycles, required %0d..%0d", n, TIMEOUT, TIMEOUT + 2);
      end
      checks++;
      if (error !== 1'b1 || dut_state !== 2'd0 || busy !== 1'b0 || done_count !== dc) begin
         errors++;
         $display("FAIL timeout_err: error=%b state=%0d busy=%b done_pulses=%0d, required error=1 state=0 busy=0 done_pulses=%0d",
                  error, dut_state, busy, done_count, dc);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: error=%b required 1", error);
      end
      $display("timeout after %0d idle cycles", n);
      start_job(12'h0AB, 12'h0CD, 12'h0EF, 12'h012);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: error=%b required 0", error);
      end
      test_param(12'h0AB, 12'h0CD, 12'h0EF, 12'h012, 1'b0);
      fill_gen(1'b0, 80);
      stream_price(30, 20, 5, 12'h7E1, 1'b0);
   endtask

   task automatic test_reset_mid_job();
      int dc;
      start_job(12'h321, 12'h654, 12'h987, 12'hCBA);
      test_param(12'h321, 12'h654, 12'h987, 12'hCBA, 1'b0);
      fill_gen(1'b0, 100);
      repeat (20) @(negedge clk);
      checks++;
      if (dut_state !== 2'd3) begin
         errors++;
         $display("FAIL midreset_in_price: state=%0d required 3", dut_state);
      end
      dc = done_count;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_state !== 2'd0 || dut_in !== 12'h000 || price !== 12'h000 ||
          busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: state=%0d dut_in=%03h price=%03h busy=%b done=%b error=%b, required all 0",
                  dut_state, dut_in, price, busy, done, error);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (done_count !== dc || dut_state !== 2'd0) begin
         errors++;
         $display("FAIL midreset_nodone: done_pulses=%0d state=%0d, required done_pulses=%0d state=0",
                  done_count, dut_state, dc);
      end
      $display("reset during price checked");
      start_job(12'h5A5, 12'hA5A, 12'h001, 12'hFFE);
      test_param(12'h5A5, 12'hA5A, 12'h001, 12'hFFE, 1'b0);
      fill_gen(1'b1, 90);
      stream_price(60, 5, 21, 12'h2C4, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_start = 0; w_in = 0; q_in = 0; s_in = 0; k_in = 0;
      dut_valid = 0; dut_out = 0; dut_resend = 0;
      test_reset();
      test_directed_job();
      test_back_to_back();
      test_wrap();
      test_timeout();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pricer_host_ctrl.md
PRICER_HOST_CTRL -- requirements
Module: pricer_host_ctrl

Interface
REQ-001 SHALL have parameter DAY, default 8, path length in 12-bit words.
REQ-002 SHALL have parameter N_PATH, default 256, paths per run; DEPTH = DAY*N_PATH (2048).
REQ-003 SHALL have parameter TIMEOUT, default 8191, maximum idle cycles waiting on the pricer in GEN or PRICE.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_start  in  1  one-cycle request to run a full pricing job.
REQ-007 w_in, q_in, s_in, k_in  in  12 each  job parameters, sampled on the accepted cmd_start.
REQ-008 dut_state  out  2  pricer mode: 0 idle, 1 parameter, 2 sobol/generate, 3 pricing.
REQ-009 dut_in  out  12  parameter word or replayed path word to the pricer.
REQ-010 dut_valid  in  1  pricer output word valid.
REQ-011 dut_out  in  12  pricer output word: path word in GEN, price in PRICE.
REQ-012 dut_resend  in  1  pricer request to replay the current path.
REQ-013 price  out  12  captured result, held until the next accepted job.
REQ-014 busy  out  1  high from accepted cmd_start until DONE or ERR is entered.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 error  out  1  sticky; set on timeout; cleared by the next accepted cmd_start.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, PARAM, GEN, PRICE, DONE, ERR.
REQ-018 IDLE: dut_state=0; cmd_start latches the 4 parameters and moves to ARM; cmd_start in any other state SHALL be ignored.
REQ-019 ARM: exactly 1 cycle, dut_state=1, dut_in=0; then PARAM.
REQ-020 PARAM: exactly 4 cycles, dut_state=1; dut_in = w, q, S, K in that order, one per cycle; then GEN.
REQ-021 GEN: dut_state=2; each cycle with dut_valid=1 SHALL write dut_out to buffer[wr_ptr] and increment wr_ptr.
REQ-022 GEN SHALL exit to PRICE in the cycle after the DEPTH-th captured word; dut_valid in the PRICE-entry cycle SHALL not be written.
REQ-023 PRICE: dut_state=3; dut_in is registered; the first PRICE cycle SHALL present buffer[0]; each following cycle advances rd_ptr by 1.
REQ-024 rd_ptr SHALL wrap from DEPTH-1 to 0 and keep streaming until the price arrives.
REQ-025 dut_resend=1 in PRICE SHALL rewind rd_ptr to the start of the current path, (rd_ptr/DAY)*DAY; the word at that address SHALL be on dut_in in the next cycle.
REQ-026 dut_valid=1 in PRICE SHALL latch dut_out into price and move to DONE; when dut_valid and dut_resend are high together, valid SHALL win.
REQ-027 DONE: 1 cycle, dut_state=0, done=1; then IDLE.
REQ-028 A watchdog counter SHALL clear on every state entry and on every dut_valid, and increment otherwise in GEN and PRICE.
REQ-029 When the watchdog reaches TIMEOUT, the FSM SHALL move to ERR with error=1; ERR drives dut_state=0 and returns to IDLE next cycle.
REQ-030 The buffer SHALL be DEPTH x 12 with a single write port and a single read port; wr_ptr and rd_ptr are log2(DEPTH) bits; wr_ptr SHALL clear on ARM.

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, dut_state=0, dut_in=0, price=0, busy=0, done=0, error=0, pointers=0, watchdog=0, parameter registers=0; buffer contents are not reset.
REQ-032 Reset asserted mid-job SHALL abort the job; no done pulse SHALL be issued.

Structure
REQ-033 A shared package SHALL hold the mode encodings (0..3), DAY, N_PATH, and the FSM state encoding.
REQ-034 The buffer SHALL be a sub-module path_buffer (synchronous write, registered read); all other logic stays in pricer_host_ctrl.

Verification
REQ-035 cmd_start with w=0x010, q=0x020, s=0x400, k=0x3C0 -> dut_state 1 for 5 cycles; dut_in = 0, 0x010, 0x020, 0x400, 0x3C0; then dut_state=2.
REQ-036 GEN with the bench supplying 2048 valid words of value addr[11:0] -> dut_state=3 after the last word; dut_in = 0, 1, 2, ... on consecutive cycles.
REQ-037 PRICE with dut_resend pulsed while dut_in=13 -> the next dut_in is 8, followed by 9, 10, ...
REQ-038 PRICE with dut_valid=1 and dut_out=0x155 -> price=0x155, a single done pulse, dut_state=0, busy=0.
REQ-039 GEN with no dut_valid for 8191 cycles -> error=1, dut_state=0, no done pulse; a new cmd_start clears error.
REQ-040 rst_n low during PRICE -> all outputs 0 immediately; a following cmd_start runs a clean job.
